// File: rtl/pq_op_scheduler.sv
// Request front-end for the register-tree priority queue: turns client enqueue/dequeue
// handshakes into single-cycle tree pulses with a settle gap. Optional stats: PQ_SCHED_STATS_EN.
module pq_op_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 4095,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_enq_valid,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  output logic                  o_enq_ready,
  input  logic                  i_deq_valid,
  output logic                  o_deq_ready,
  output logic                  o_deq_data_valid,
  output logic [DATA_WIDTH-1:0] o_deq_data,
  output logic                  o_zero_drop,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data,
  output logic [1:0]            o_dbg_state
`ifdef PQ_SCHED_STATS_EN
  ,
  output logic [31:0]           o_op_count,
  output logic [31:0]           o_drop_count
`endif
);

  if (GAP_CYCLES < 0 || GAP_CYCLES > 255 || QUEUE_SIZE < 1) begin : g_bad_param
    $error("pq_op_scheduler: GAP_CYCLES must be 0..255 and QUEUE_SIZE positive");
  end

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  // Handshake: a request transfers on a rising clock edge where valid and ready are
  // both high; valid may stay high indefinitely while ready is low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OP = 2'd1, S_SETTLE = 2'd2} state_t;

  state_t                r_state;
  logic [7:0]            r_gap_cnt;
  logic                  r_pq_wrt;
  logic                  r_pq_read;
  logic [DATA_WIDTH-1:0] r_pq_data;
  logic                  r_zero_drop;
  logic                  r_deq_data_valid;
  logic [DATA_WIDTH-1:0] r_deq_data;

  logic w_idle;
  logic w_enq_acc;
  logic w_deq_acc;
  logic w_wrt;
  logic w_drop;

  // Full/empty are only trusted in IDLE; ready is forced low while reset is asserted.
  assign w_idle      = (r_state == S_IDLE) && i_RSTn;
  assign o_deq_ready = w_idle && !i_pq_empty;
  assign o_enq_ready = w_idle && (!i_pq_full || (i_deq_valid && !i_pq_empty));
  assign w_enq_acc   = i_enq_valid && o_enq_ready;
  assign w_deq_acc   = i_deq_valid && o_deq_ready;
  assign w_wrt       = w_enq_acc && (|i_enq_data);
  assign w_drop      = w_enq_acc && ~(|i_enq_data);

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state          <= S_IDLE;
      r_gap_cnt        <= 8'd0;
      r_pq_wrt         <= 1'b0;
      r_pq_read        <= 1'b0;
      r_pq_data        <= '0;
      r_zero_drop      <= 1'b0;
      r_deq_data_valid <= 1'b0;
      r_deq_data       <= '0;
    end else begin
      r_pq_wrt         <= 1'b0;
      r_pq_read        <= 1'b0;
      r_zero_drop      <= 1'b0;
      r_deq_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_zero_drop <= w_drop;
          if (w_wrt) r_pq_data <= i_enq_data;
          if (w_wrt || w_deq_acc) begin
            r_pq_wrt  <= w_wrt;
            r_pq_read <= w_deq_acc;
            r_state   <= S_OP;
          end
        end
        S_OP: begin
          // The read pulse is still high here, so it marks a dequeue awaiting its root value.
          if (r_pq_read) begin
            r_deq_data       <= i_pq_data;
            r_deq_data_valid <= 1'b1;
          end
          if (GAP_LOAD == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_SETTLE;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        S_SETTLE: begin
          if (r_gap_cnt <= 8'd1) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= 8'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pq_wrt         = r_pq_wrt;
  assign o_pq_read        = r_pq_read;
  assign o_pq_data        = r_pq_data;
  assign o_zero_drop      = r_zero_drop;
  assign o_deq_data_valid = r_deq_data_valid;
  assign o_deq_data       = r_deq_data;
  assign o_dbg_state      = r_state;

`ifdef PQ_SCHED_STATS_EN
  logic [31:0] r_op_count;
  logic [31:0] r_drop_count;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_op_count   <= 32'd0;
      r_drop_count <= 32'd0;
    end else begin
      if ((r_pq_wrt || r_pq_read) && (r_op_count != 32'hFFFF_FFFF))
        r_op_count <= r_op_count + 32'd1;
      if (r_zero_drop && (r_drop_count != 32'hFFFF_FFFF))
        r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign o_op_count   = r_op_count;
  assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_pq_op_scheduler.sv
// Bench for pq_op_scheduler: directed vector table, hand sequences and randomized traffic
// checked against a transaction-level timing model. Covers PQ_SCHED_STATS_EN when defined.
`timescale 1ns/1ps
module tb_pq_op_scheduler;

  localparam int DW  = 16;
  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enq_v, deq_v, full, empty;
  logic [DW-1:0] enq_d, pq_d;
  wire           enq_rdy, deq_rdy, dv, zdrop, pq_wrt, pq_read;
  wire  [DW-1:0] deq_data, pq_wdata;
  wire  [1:0]    dbg_state;
`ifdef PQ_SCHED_STATS_EN
  wire  [31:0]   op_count, drop_count;
`endif

  pq_op_scheduler #(.DATA_WIDTH(DW), .QUEUE_SIZE(4095), .GAP_CYCLES(GAP)) dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_enq_valid(enq_v), .i_enq_data(enq_d), .o_enq_ready(enq_rdy),
    .i_deq_valid(deq_v), .o_deq_ready(deq_rdy),
    .o_deq_data_valid(dv), .o_deq_data(deq_data), .o_zero_drop(zdrop),
    .o_pq_wrt(pq_wrt), .o_pq_read(pq_read), .o_pq_data(pq_wdata),
    .i_pq_full(full), .i_pq_empty(empty), .i_pq_data(pq_d),
    .o_dbg_state(dbg_state)
`ifdef PQ_SCHED_STATS_EN
    , .o_op_count(op_count), .o_drop_count(drop_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  int   cyc, free_at, cap_at;
  logic exp_wrt, exp_read, exp_drop, exp_dv;
  logic [DW-1:0] exp_wd;
  logic last_enq_acc, last_deq_acc;
  int   m_ops, m_drops;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Busy window: an operation accepted in cycle t blocks acceptance until cycle t+2+GAP.
  function automatic logic m_idle();
    return cyc >= free_at;
  endfunction
  function automatic logic m_deq_rdy();
    return m_idle() && !empty;
  endfunction
  function automatic logic m_enq_rdy();
    return m_idle() && (!full || (deq_v && !empty));
  endfunction

  task automatic model_reset();
    exp_q.delete();
    free_at = 0; cap_at = -1;
    exp_wrt = 0; exp_read = 0; exp_drop = 0; exp_dv = 0; exp_wd = '0;
    last_enq_acc = 0; last_deq_acc = 0;
    m_ops = 0; m_drops = 0;
  endtask

  task automatic commit();
    logic acc_e, acc_d, ndv;
    m_ops   += (exp_wrt || exp_read) ? 1 : 0;
    m_drops += exp_drop ? 1 : 0;
    ndv = 1'b0;
    if (cap_at == cyc) begin
      exp_q.push_back(pq_d);
      ndv = 1'b1;
      cap_at = -1;
    end
    acc_e = enq_v && m_enq_rdy();
    acc_d = deq_v && m_deq_rdy();
    exp_wrt  = acc_e && (enq_d != 0);
    exp_read = acc_d;
    exp_drop = acc_e && (enq_d == 0);
    if (exp_wrt) exp_wd = enq_d;
    if (exp_wrt || exp_read) free_at = cyc + 2 + GAP;
    if (acc_d) cap_at = cyc + 1;
    exp_dv = ndv;
    last_enq_acc = acc_e;
    last_deq_acc = acc_d;
    cyc++;
  endtask

  task automatic check_outputs();
    logic [DW-1:0] e;
    cmp("pq_wrt", pq_wrt, exp_wrt);
    cmp("pq_read", pq_read, exp_read);
    cmp("zero_drop", zdrop, exp_drop);
    if (exp_wrt) cmp("pq_data", pq_wdata, exp_wd);
    cmp("deq_valid", dv, exp_dv);
    if (exp_dv) begin
      if (exp_q.size() == 0) begin
        cmp("deq_queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        cmp("deq_data", deq_data, e);
      end
    end
`ifdef PQ_SCHED_STATS_EN
    cmp("op_count", op_count, m_ops);
    cmp("drop_count", drop_count, m_drops);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic ev, input logic [DW-1:0] ed, input logic dq,
                        input logic f, input logic em, input logic [DW-1:0] pd);
    enq_v = ev; enq_d = ed; deq_v = dq; full = f; empty = em; pq_d = pd;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge after checking.
  task automatic tick();
    #1;
    cmp("enq_ready", enq_rdy, m_enq_rdy());
    cmp("deq_ready", deq_rdy, m_deq_rdy());
    @(posedge clk);
    commit();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    cmp("rst_pq_wrt", pq_wrt, 0);
    cmp("rst_pq_read", pq_read, 0);
    cmp("rst_pq_data", pq_wdata, 0);
    cmp("rst_zero_drop", zdrop, 0);
    cmp("rst_deq_valid", dv, 0);
    cmp("rst_deq_data", deq_data, 0);
    cmp("rst_enq_ready", enq_rdy, 0);
    cmp("rst_deq_ready", deq_rdy, 0);
    cmp("rst_state", dbg_state, 0);
`ifdef PQ_SCHED_STATS_EN
    cmp("rst_op_count", op_count, 0);
    cmp("rst_drop_count", drop_count, 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    enq_v = 0; deq_v = 0;
    while ((cyc < free_at || cap_at >= 0 || exp_q.size() != 0) && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) cmp("wait_idle_timeout", guard, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          enq_v;
    logic [DW-1:0] enq_d;
    logic          deq_v;
    logic          full;
    logic          empty;
    logic [DW-1:0] pq_d;
    logic          e_enq_rdy;
    logic          e_deq_rdy;
    logic          e_wrt;
    logic          e_read;
    logic          e_drop;
    logic          e_dv;
    logic [DW-1:0] e_dd;
  } vec_t;

  vec_t vt[7];

  task automatic apply_vec(input vec_t v);
    wait_idle();
    set_in(v.enq_v, v.enq_d, v.deq_v, v.full, v.empty, v.pq_d);
    #1;
    cmp("tbl_enq_ready", enq_rdy, v.e_enq_rdy);
    cmp("tbl_deq_ready", deq_rdy, v.e_deq_rdy);
    tick();
    cmp("tbl_pq_wrt", pq_wrt, v.e_wrt);
    cmp("tbl_pq_read", pq_read, v.e_read);
    cmp("tbl_zero_drop", zdrop, v.e_drop);
    if (v.e_wrt) cmp("tbl_pq_data", pq_wdata, v.enq_d);
    enq_v = 0; deq_v = 0;
    tick();
    cmp("tbl_deq_valid", dv, v.e_dv);
    if (v.e_dv) cmp("tbl_deq_data", deq_data, v.e_dd);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    //          enq_v enq_d     deq full empty pq_d       erdy drdy wrt rd drop dv dd
    vt[0] = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0009};
    vt[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0007};
    vt[3] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[4] = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234};
    vt[5] = '{1'b1, 16'hABCD, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vt[6] = '{1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    cyc = 0;
    model_reset();
    rst_n = 1'b0;
    set_in(0, '0, 0, 0, 0, '0);
    repeat (2) @(negedge clk);
    reset_pulse();

    for (int i = 0; i < 7; i++) apply_vec(vt[i]);

    // Ready stays low for the OP cycle plus GAP settle cycles, then returns.
    wait_idle();
    set_in(1, 16'h0005, 0, 0, 1, '0);
    tick();
    cmp("seq_gap_wrt", pq_wrt, 1);
    enq_v = 0;
    for (int k = 0; k < GAP + 1; k++) begin
      #1 cmp("seq_gap_enq_ready_low", enq_rdy, 0);
      tick();
    end
    #1 cmp("seq_gap_enq_ready_back", enq_rdy, 1);

    // Dequeue held while empty: no read until empty drops.
    wait_idle();
    set_in(0, '0, 1, 0, 1, '0);
    repeat (3) begin
      #1 cmp("seq_empty_deq_ready", deq_rdy, 0);
      tick();
      cmp("seq_empty_no_read", pq_read, 0);
    end
    empty = 0; pq_d = 16'h00A5;
    #1 cmp("seq_empty_deq_ready_back", deq_rdy, 1);
    tick();
    cmp("seq_empty_read", pq_read, 1);
    deq_v = 0;
    tick();
    cmp("seq_empty_deq_valid", dv, 1);

    // Reset in the OP cycle of a dequeue: result is lost.
    wait_idle();
    set_in(0, '0, 1, 0, 0, 16'h0055);
    tick();
    cmp("seq_rst_read", pq_read, 1);
    reset_pulse();
    deq_v = 0;
    repeat (4) begin
      tick();
      cmp("seq_rst_no_deq_valid", dv, 0);
    end

    // Randomized traffic; unaccepted requests are held until they transfer.
    for (int i = 0; i < 600; i++) begin
      if (!(enq_v && !last_enq_acc)) begin
        enq_v = 1'($urandom_range(0, 1));
        enq_d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      end
      if (!(deq_v && !last_deq_acc)) deq_v = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      full  = (r == 0);
      empty = (r == 1);
      pq_d  = DW'($urandom);
      if ($urandom_range(0, 149) == 0) reset_pulse();
      tick();
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
